seq_mag_comp: RTL and testbench



---
 rtl/seq_mag_comp.sv | 122 ++++++++++++
 tb/tb_seq_mag_comp.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mag_comp.sv
// Multi-cycle magnitude comparator: walks both operands MSB-first, CHUNK bits per
// RUN cycle, and reports lt/eq/gt plus the number of RUN cycles used.
module seq_mag_comp #(
   parameter  int WIDTH      = 16,
   parameter  int CHUNK      = 4,
   parameter  int EARLY_EXIT = 1,
   localparam int NCHUNK     = WIDTH / CHUNK,
   localparam int CW         = $clog2(NCHUNK + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             lt,
   output logic             eq,
   output logic             gt,
   output logic [CW-1:0]    cycles
);

   localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [CW-1:0]    cycles_q, cycles_d;
   logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;

   // Operands shift left each RUN cycle, so the chunk under test is always the top one.
   logic [CHUNK-1:0] chunk_a, chunk_b;
   logic             differ, found;

   assign chunk_a = a_q[WIDTH-1 -: CHUNK];
   assign chunk_b = b_q[WIDTH-1 -: CHUNK];
   assign differ  = (chunk_a != chunk_b);
   assign found   = lt_q | gt_q;

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      idx_d    = idx_q;
      cycles_d = cycles_q;
      lt_d     = lt_q;
      eq_d     = eq_q;
      gt_d     = gt_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               // Flipping the sign bit of both operands turns a signed compare into an unsigned one.
               a_d              = a;
               b_d              = b;
               a_d[WIDTH-1]     = a[WIDTH-1] ^ signed_mode;
               b_d[WIDTH-1]     = b[WIDTH-1] ^ signed_mode;
               idx_d            = '0;
               cycles_d         = '0;
               lt_d             = 1'b0;
               eq_d             = 1'b0;
               gt_d             = 1'b0;
               state_d          = S_RUN;
            end
         end
         S_RUN: begin
            cycles_d = cycles_q + CW'(1);
            a_d      = a_q << CHUNK;
            b_d      = b_q << CHUNK;
            if (differ && !found) begin
               gt_d = (chunk_a > chunk_b);
               lt_d = (chunk_a < chunk_b);
            end
            if ((differ && !found && (EARLY_EXIT != 0)) || (idx_q == IW'(NCHUNK - 1))) begin
               eq_d    = !(found || differ);
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all of them update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         idx_q    <= '0;
         cycles_q <= '0;
         lt_q     <= 1'b0;
         eq_q     <= 1'b0;
         gt_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         idx_q    <= idx_d;
         cycles_q <= cycles_d;
         lt_q     <= lt_d;
         eq_q     <= eq_d;
         gt_q     <= gt_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign out_valid = (state_q == S_DONE);
   assign lt        = lt_q;
   assign eq        = eq_q;
   assign gt        = gt_q;
   assign cycles    = cycles_q;

endmodule

// File: tb/tb_seq_mag_comp.sv
// Bench for seq_mag_comp: four configurations driven in lockstep, checked against
// a table of directed vectors and an arithmetic compare model.
module tb_seq_mag_comp;

   localparam int W_T [4] = '{16, 16, 32, 8};
   localparam int C_T [4] = '{4, 4, 8, 8};
   localparam int E_T [4] = '{1, 0, 1, 1};

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sgn;
      logic [2:0]  fl;   // {lt, eq, gt}
      int          k0;   // RUN cycles for the 16/4 early-exit instance
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        stim_s = 1'b0;
   logic [31:0] stim_a = '0;
   logic [31:0] stim_b = '0;

   logic [3:0]  ir_w, ov_w, lt_w, eq_w, gt_w;
   logic [2:0]  cy0, cy1, cy2;
   logic        cy3;
   logic [2:0]  cy_w [4];

   int          total = 0;
   int          bad = 0;
   vec_t        tab [7];

   logic [3:0]  cap;
   logic [2:0]  cap_fl [4];
   logic [2:0]  cap_cy [4];
   int          cap_lat [4];

   always #5 clk = ~clk;

   always_comb begin
      cy_w[0] = cy0;
      cy_w[1] = cy1;
      cy_w[2] = cy2;
      cy_w[3] = {2'b00, cy3};
   end

   seq_mag_comp #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w[0]),
      .a(stim_a[15:0]), .b(stim_b[15:0]), .signed_mode(stim_s),
      .out_valid(ov_w[0]), .out_ready(out_ready),
      .lt(lt_w[0]), .eq(eq_w[0]), .gt(gt_w[0]), .cycles(cy0));

   seq_mag_comp #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(0)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w[1]),
      .a(stim_a[15:0]), .b(stim_b[15:0]), .signed_mode(stim_s),
      .out_valid(ov_w[1]), .out_ready(out_ready),
      .lt(lt_w[1]), .eq(eq_w[1]), .gt(gt_w[1]), .cycles(cy1));

   seq_mag_comp #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) u2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w[2]),
      .a(stim_a), .b(stim_b), .signed_mode(stim_s),
      .out_valid(ov_w[2]), .out_ready(out_ready),
      .lt(lt_w[2]), .eq(eq_w[2]), .gt(gt_w[2]), .cycles(cy2));

   seq_mag_comp #(.WIDTH(8), .CHUNK(8), .EARLY_EXIT(1)) u3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w[3]),
      .a(stim_a[7:0]), .b(stim_b[7:0]), .signed_mode(stim_s),
      .out_valid(ov_w[3]), .out_ready(out_ready),
      .lt(lt_w[3]), .eq(eq_w[3]), .gt(gt_w[3]), .cycles(cy3));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Flags come from a plain integer compare; k from the first differing chunk.
   function automatic void model(input int i, input logic [31:0] av, input logic [31:0] bv,
                                 input logic sv, output logic [2:0] fl, output int k);
      int      w   = W_T[i];
      int      c   = C_T[i];
      int      nch = w / c;
      longint  ua, ub, sa, sb, mask, cmask;
      mask  = (64'sd1 <<< w) - 1;
      cmask = (64'sd1 <<< c) - 1;
      ua = longint'({32'b0, av}) & mask;
      ub = longint'({32'b0, bv}) & mask;
      sa = ua;
      sb = ub;
      if (sv && ua[w-1]) sa = ua - (64'sd1 <<< w);
      if (sv && ub[w-1]) sb = ub - (64'sd1 <<< w);
      fl = (sa < sb) ? 3'b100 : (sa == sb) ? 3'b010 : 3'b001;
      k  = nch;
      if (E_T[i] != 0)
         for (int j = nch - 1; j >= 0; j--)
            if (((ua >> (w - (j + 1) * c)) & cmask) != ((ub >> (w - (j + 1) * c)) & cmask))
               k = j + 1;
   endfunction

   task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                           input bit rnd_ready);
      int n;
      check("in_ready_before_accept", ir_w, 4'hF);
      @(negedge clk);
      stim_a    = av;
      stim_b    = bv;
      stim_s    = sv;
      in_valid  = 1'b1;
      out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      cap = '0;
      n = 0;
      while (cap != 4'hF && n < 40) begin
         @(negedge clk);
         n++;
         for (int i = 0; i < 4; i++)
            if (ov_w[i] && !cap[i]) begin
               cap[i]     = 1'b1;
               cap_fl[i]  = {lt_w[i], eq_w[i], gt_w[i]};
               cap_cy[i]  = cy_w[i];
               cap_lat[i] = n;
            end
         if (rnd_ready) out_ready = ($urandom_range(0, 2) != 0);
      end
      check("done_timeout", cap, 4'hF);
   endtask

   task automatic finish_op(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                            input bit use_tab, input logic [2:0] tfl, input int tk0);
      int         n;
      logic [2:0] efl;
      int         ek;
      out_ready = 1'b1;
      n = 0;
      while (ir_w != 4'hF && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("return_to_idle", ir_w, 4'hF);
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         model(i, av, bv, sv, efl, ek);
         check($sformatf("u%0d_flags a=%0h b=%0h s=%0d", i, av, bv, sv), cap_fl[i], efl);
         check($sformatf("u%0d_cycles a=%0h b=%0h", i, av, bv), cap_cy[i], ek);
         check($sformatf("u%0d_latency a=%0h b=%0h", i, av, bv), cap_lat[i], ek);
      end
      if (use_tab) begin
         check($sformatf("tab_u0_flags a=%0h b=%0h", av, bv), cap_fl[0], tfl);
         check($sformatf("tab_u0_cycles a=%0h b=%0h", av, bv), cap_cy[0], tk0);
         check($sformatf("tab_u1_flags a=%0h b=%0h", av, bv), cap_fl[1], tfl);
         check($sformatf("tab_u1_cycles a=%0h b=%0h", av, bv), cap_cy[1], 4);
      end
   endtask

   task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                         input bit use_tab, input logic [2:0] tfl, input int tk0);
      start_op(av, bv, sv, 1'b1);
      finish_op(av, bv, sv, use_tab, tfl, tk0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic        rs;

      tab[0] = '{32'h1234, 32'h1234, 1'b0, 3'b010, 4};
      tab[1] = '{32'h8000, 32'h7FFF, 1'b0, 3'b001, 1};
      tab[2] = '{32'h8000, 32'h7FFF, 1'b1, 3'b100, 1};
      tab[3] = '{32'hFFFF, 32'h0000, 1'b1, 3'b100, 1};
      tab[4] = '{32'h1235, 32'h1234, 1'b0, 3'b001, 4};
      tab[5] = '{32'h2000, 32'h1FFF, 1'b0, 3'b001, 1};
      tab[6] = '{32'h0001, 32'h0002, 1'b0, 3'b100, 4};

      // Reset state.
      #2;
      check("rst_in_ready", ir_w, 4'h0);
      check("rst_out_valid", ov_w, 4'h0);
      check("rst_flags", {lt_w, eq_w, gt_w}, 12'h0);
      check("rst_cycles", {cy0, cy1, cy2, cy3}, 10'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("release_in_ready", ir_w, 4'hF);

      for (int t = 0; t < 7; t++)
         run_op(tab[t].a, tab[t].b, tab[t].sgn, 1'b1, tab[t].fl, tab[t].k0);

      // Stall in DONE while the input side wiggles.
      start_op(32'h1234, 32'h1235, 1'b0, 1'b0);
      for (int s = 0; s < 5; s++) begin
         in_valid = ~in_valid;
         stim_a   = $urandom;
         stim_b   = $urandom;
         @(negedge clk);
         check("stall_u0_flags", {lt_w[0], eq_w[0], gt_w[0]}, cap_fl[0]);
         check("stall_u0_cycles", cy_w[0], cap_cy[0]);
         check("stall_in_ready", ir_w, 4'h0);
         check("stall_out_valid", ov_w, 4'hF);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("release_idle_in_ready", ir_w, 4'hF);
      check("release_idle_out_valid", ov_w, 4'h0);
      finish_op(32'h1234, 32'h1235, 1'b0, 1'b1, 3'b100, 4);

      // Asynchronous reset during the second RUN cycle.
      @(negedge clk);
      stim_a   = 32'h1234;
      stim_b   = 32'h1234;
      stim_s   = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrun_rst_out_valid", ov_w, 4'h0);
      check("midrun_rst_flags", {lt_w, eq_w, gt_w}, 12'h0);
      check("midrun_rst_cycles", {cy0, cy1, cy2, cy3}, 10'h0);
      check("midrun_rst_in_ready", ir_w, 4'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrun_release_in_ready", ir_w, 4'hF);
      run_op(32'h0001, 32'h0002, 1'b0, 1'b1, 3'b100, 4);

      // Random regression with out_ready stalls.
      for (int r = 0; r < 60; r++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = ra ^ (32'd1 << $urandom_range(0, 31));
            default: rb = $urandom;
         endcase
         rs = 1'($urandom_range(0, 1));
         run_op(ra, rb, rs, 1'b0, 3'b000, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
